// File: rtl/moisture_sample_scheduler.sv
// Periodic soil-moisture sampler: bursts of ADC reads are averaged, scaled to a
// 0..100 percentage by serial division, and drive a hysteretic pump request.
module moisture_sample_scheduler #(
  parameter int SAMPLE_PERIOD = 1000,
  parameter int AVG_LOG2      = 2,
  parameter int TIMEOUT       = 255,
  parameter int DRY_RAW       = 800,
  parameter int WET_RAW       = 300,
  parameter int PUMP_ON_PCT   = 30,
  parameter int PUMP_OFF_PCT  = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       adc_start,
  input  logic       adc_busy,
  input  logic       adc_done,
  input  logic [9:0] adc_data,
  output logic [7:0] moisture_percentage,
  output logic       pct_valid,
  output logic       pump_on,
  output logic       adc_error
);

  localparam int ACC_W = 11 + AVG_LOG2;
  localparam int PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int SC_W  = AVG_LOG2 + 1;
  localparam int REM_W = 24;

  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'((1 << AVG_LOG2) - 1);
  localparam logic [9:0]       DRY_C    = 10'(DRY_RAW);
  localparam logic [9:0]       WET_C    = 10'(WET_RAW);
  localparam logic [REM_W-1:0] DEN_C    = REM_W'(DRY_RAW - WET_RAW);
  localparam logic [REM_W-1:0] HUNDRED  = REM_W'(100);
  localparam logic [7:0]       ON_C     = 8'(PUMP_ON_PCT);
  localparam logic [7:0]       OFF_C    = 8'(PUMP_OFF_PCT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT    = 3'd2,
    AVG     = 3'd3,
    CONVERT = 3'd4,
    UPDATE  = 3'd5
  } state_t;

  state_t             state_r;
  logic [PER_W-1:0]   period_cnt_r;
  logic [TO_W-1:0]    timeout_cnt_r;
  logic [SC_W-1:0]    sample_cnt_r;
  logic [ACC_W-1:0]   acc_r;
  logic [9:0]         avg_r;
  logic [REM_W-1:0]   rem_r;
  logic [7:0]         quot_r;
  logic [7:0]         moisture_r;
  logic               pct_valid_r;
  logic               pump_on_r;
  logic               adc_start_r;
  logic               adc_error_r;

  logic               tick_s;
  logic               timeout_s;
  logic [9:0]         avg_s;
  logic [9:0]         diff_s;
  logic               clamp_dry_s;
  logic               clamp_wet_s;
  logic               conv_done_s;
  logic [7:0]         final_pct_s;

  function automatic logic next_pump(input logic [7:0] pct, input logic cur);
    if (pct < ON_C) begin
      return 1'b1;
    end else if (pct >= OFF_C) begin
      return 1'b0;
    end else begin
      return cur;
    end
  endfunction

  assign tick_s      = enable && (period_cnt_r == PER_LAST);
  assign timeout_s   = (timeout_cnt_r == TO_LAST);
  assign avg_s       = 10'(acc_r >> AVG_LOG2);
  // Only meaningful when avg_s < DRY_C; the clamp checks in CONVERT guard the rest.
  assign diff_s      = DRY_C - avg_s;
  assign clamp_dry_s = (avg_r >= DRY_C);
  assign clamp_wet_s = (avg_r <= WET_C);
  assign conv_done_s = clamp_dry_s || clamp_wet_s || (rem_r < DEN_C);
  assign final_pct_s = clamp_dry_s ? 8'd0 : (clamp_wet_s ? 8'd100 : quot_r);

  // Period counter, sampling FSM, serial divider and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      period_cnt_r  <= '0;
      timeout_cnt_r <= '0;
      sample_cnt_r  <= '0;
      acc_r         <= '0;
      avg_r         <= 10'd0;
      rem_r         <= '0;
      quot_r        <= 8'd0;
      moisture_r    <= 8'd0;
      pct_valid_r   <= 1'b0;
      pump_on_r     <= 1'b0;
      adc_start_r   <= 1'b0;
      adc_error_r   <= 1'b0;
    end else begin
      adc_start_r <= 1'b0;
      pct_valid_r <= 1'b0;

      if (!enable || tick_s) begin
        period_cnt_r <= '0;
      end else begin
        period_cnt_r <= period_cnt_r + PER_W'(1);
      end

      case (state_r)
        IDLE: begin
          timeout_cnt_r <= '0;
          if (tick_s) begin
            state_r <= START;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          if (timeout_s) begin
            adc_error_r   <= 1'b1;
            acc_r         <= '0;
            sample_cnt_r  <= '0;
            timeout_cnt_r <= '0;
            state_r       <= IDLE;
          end else if (!adc_busy) begin
            adc_start_r   <= 1'b1;
            timeout_cnt_r <= timeout_cnt_r + TO_W'(1);
            state_r       <= WAIT;
          end else begin
            timeout_cnt_r <= timeout_cnt_r + TO_W'(1);
            state_r       <= START;
          end
        end
        WAIT: begin
          // A result arriving on the last allowed cycle still counts.
          if (adc_done) begin
            acc_r         <= acc_r + ACC_W'(adc_data);
            timeout_cnt_r <= '0;
            if (sample_cnt_r == SC_LAST) begin
              sample_cnt_r <= '0;
              state_r      <= AVG;
            end else begin
              sample_cnt_r <= sample_cnt_r + SC_W'(1);
              state_r      <= START;
            end
          end else if (timeout_s) begin
            adc_error_r   <= 1'b1;
            acc_r         <= '0;
            sample_cnt_r  <= '0;
            timeout_cnt_r <= '0;
            state_r       <= IDLE;
          end else begin
            timeout_cnt_r <= timeout_cnt_r + TO_W'(1);
            state_r       <= WAIT;
          end
        end
        AVG: begin
          avg_r        <= avg_s;
          rem_r        <= REM_W'(diff_s) * HUNDRED;
          quot_r       <= 8'd0;
          acc_r        <= '0;
          sample_cnt_r <= '0;
          state_r      <= CONVERT;
        end
        CONVERT: begin
          if (conv_done_s) begin
            moisture_r  <= final_pct_s;
            pct_valid_r <= 1'b1;
            pump_on_r   <= next_pump(final_pct_s, pump_on_r);
            state_r     <= UPDATE;
          end else begin
            rem_r   <= rem_r - DEN_C;
            quot_r  <= quot_r + 8'd1;
            state_r <= CONVERT;
          end
        end
        UPDATE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign adc_start           = adc_start_r;
  assign moisture_percentage = moisture_r;
  assign pct_valid           = pct_valid_r;
  assign pump_on             = pump_on_r;
  assign adc_error           = adc_error_r;

endmodule

// File: doc/moisture_sample_scheduler.md
MOISTURE_SAMPLE_SCHEDULER -- requirements
Module: moisture_sample_scheduler

Interface
REQ-001 SHALL provide parameters (name, default, meaning):
- SAMPLE_PERIOD, 1000: clk cycles between burst starts.
- AVG_LOG2, 2: log2 of samples per burst.
- TIMEOUT, 255: max cycles spent in START+WAIT per sample.
- DRY_RAW, 800: raw ADC code meaning 0 %.
- WET_RAW, 300: raw ADC code meaning 100 %.
- PUMP_ON_PCT, 30: pump turn-on threshold.
- PUMP_OFF_PCT, 60: pump turn-off threshold.
REQ-002 SHALL provide ports (name, direction, width, meaning):
- clk  in  1: the single clock.
- reset  in  1: synchronous, active-high.
- enable  in  1: periodic sampling enable.
- adc_start  out  1: one-cycle conversion request.
- adc_busy  in  1: ADC is converting.
- adc_done  in  1: one-cycle result-valid pulse.
- adc_data  in  10: raw result, valid with adc_done.
- moisture_percentage  out  8: percentage, 0..100.
- pct_valid  out  1: one-cycle update strobe.
- pump_on  out  1: irrigation request.
- adc_error  out  1: sticky timeout flag.
REQ-003 SHALL require DRY_RAW > WET_RAW and PUMP_ON_PCT < PUMP_OFF_PCT <= 100; behaviour is undefined otherwise.

Function
REQ-004 SHALL implement the FSM states IDLE, START, WAIT, AVG, CONVERT, UPDATE.
REQ-005 SHALL hold the period counter at 0 while enable=0; while enable=1 it SHALL increment, wrap at SAMPLE_PERIOD-1 and raise a tick.
REQ-006 SHALL start a burst (IDLE->START) on a tick in IDLE; a tick outside IDLE SHALL be dropped, not queued.
REQ-007 SHALL, in START, assert adc_start for exactly one cycle when adc_busy=0, then go to WAIT; while adc_busy=1 it SHALL remain in START with adc_start=0.
REQ-008 SHALL, in WAIT, add adc_data on adc_done into a (11+AVG_LOG2)-bit accumulator; it SHALL then return to START, or go to AVG after the 2^AVG_LOG2-th sample.
REQ-009 SHALL ignore adc_done in all states except WAIT.
REQ-010 SHALL reset a per-sample timeout counter on entering START; if TIMEOUT cycles elapse without adc_done, it SHALL:
- set adc_error;
- clear the accumulator and sample count;
- return to IDLE with no pct_valid and no pump change.
REQ-011 SHALL compute avg = accumulator >> AVG_LOG2 (truncation) in AVG, one cycle.
REQ-012 SHALL, in CONVERT, produce pct as follows:
- avg >= DRY_RAW gives 0.
- avg <= WET_RAW gives 100.
- otherwise pct = floor((DRY_RAW-avg)*100 / (DRY_RAW-WET_RAW)), by repeated subtraction, one subtraction per cycle, no hardware divider.
REQ-013 SHALL have the latency: final adc_done at cycle t; avg at t+1; pct_valid at t+3+Q, where Q is the quotient (Q=0 for clamped cases).
REQ-014 SHALL, in UPDATE (one cycle), register moisture_percentage, pulse pct_valid and update pump_on in the same cycle, then return to IDLE.
REQ-015 SHALL apply pump hysteresis:
- pct < PUMP_ON_PCT sets pump_on=1.
- pct >= PUMP_OFF_PCT sets pump_on=0.
- otherwise pump_on holds.
REQ-016 SHALL let a burst already in progress complete when enable deasserts.
REQ-017 SHALL hold moisture_percentage and pump_on between updates.
REQ-018 SHALL clear adc_error only by reset; adc_error SHALL not block further bursts.

Reset
REQ-019 SHALL, on a cycle with reset=1, set in the next state:
- FSM to IDLE;
- all counters and the accumulator to 0;
- moisture_percentage=0, pct_valid=0, pump_on=0, adc_start=0, adc_error=0.
REQ-020 SHALL give reset priority over every other event, including reset mid-burst and mid-CONVERT.

Verification
REQ-021 Bench SHALL use SAMPLE_PERIOD=20 and other defaults, and SHALL cover:
- Samples 550,550,550,550 -> moisture_percentage=50, one pct_valid pulse 53 cycles after final adc_done, pump_on stays 0.
- Samples 301,302,303,304 -> avg 302, moisture_percentage=99 (truncated).
- Four samples of 900 -> 0, pump_on=1; then four of 200 -> 100, pump_on=0.
- avg 675 -> 25, pump_on=1; then avg 575 -> 45, pump_on holds 1; then avg 500 -> 60, pump_on=0.
- adc_done withheld 255 cycles -> adc_error=1, no pct_valid; next burst of 550s -> 50, adc_error still 1.
- Reset asserted mid-CONVERT -> next cycle all outputs 0 and FSM IDLE; adc_busy=1 at START -> adc_start held 0 until busy drops.
